// File: rtl/sink_fsm.sv
// Receiving end of a four-phase req/ack handshake: synchronizes req, captures the held word,
// strobes it to the consumer and counts transfers. Optional watchdog: define SINK_FSM_TIMEOUT_EN.
module sink_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int COUNT_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   ready,
    output logic                   ack,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   data_valid,
    output logic [COUNT_WIDTH-1:0] xfer_count,
    output logic                   timeout
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACK_HIGH = 2'd1;
`ifdef SINK_FSM_TIMEOUT_EN
    localparam logic [1:0] ERR      = 2'd2;
    localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [1:0]             state_q, state_d;
    logic                   ack_q, ack_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
`ifdef SINK_FSM_TIMEOUT_EN
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic                   timeout_q, timeout_d;
`endif

    // Only req crosses domains; data_in is held stable by the source while req is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], req};
    end
    assign req_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        count_d   = count_q;
`ifdef SINK_FSM_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (req_s && ready) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    count_d = count_q + 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACK_HIGH;
`ifdef SINK_FSM_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            ACK_HIGH: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
`ifdef SINK_FSM_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    ack_d     = 1'b0;
                    state_d   = ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ERR: begin
                // Drain the stuck request without capturing it again.
                ack_d = 1'b0;
                if (!req_s) state_d = IDLE;
`endif
            end
            default: begin
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ack_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            count_q   <= '0;
`ifdef SINK_FSM_TIMEOUT_EN
            tcnt_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            count_q   <= count_d;
`ifdef SINK_FSM_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign ack        = ack_q;
    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign xfer_count = count_q;
`ifdef SINK_FSM_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule
